piloop_mc: RTL and testbench

// Time-multiplexed multi-channel PI controller: NCH loops share one multiplier pair and one adder chain.

---
 rtl/piloop_mc_pkg.sv | 26 ++
 rtl/piloop_mc_if.sv | 41 ++++
 rtl/piloop_sat.sv | 44 ++++
 rtl/piloop_mc.sv | 210 +++++++++++++++++++++
 tb/tb_piloop_mc.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/piloop_mc_pkg.sv
// ============================================================================
// piloop_mc_pkg : shared width helpers and saturation flag encoding
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package piloop_mc_pkg;

    // Channel index width: at least one bit even for a single loop
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int integ_w(input int win, input int wk, input int winte);
        return win + wk + winte;
    endfunction

    typedef enum logic [1:0] {
        SAT_NONE = 2'b00,
        SAT_LO   = 2'b01,
        SAT_HI   = 2'b10
    } sat_e;

endpackage

`default_nettype wire

// File: rtl/piloop_mc_if.sv
// ============================================================================
// piloop_mc_if : sample-in / result-out bundle of the multi-channel PI loop
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface piloop_mc_if #(
    parameter int NCH   = 4,
    parameter int WIN   = 16,
    parameter int WK    = 16,
    parameter int PK    = 7,
    parameter int WINTE = 8,
    parameter int WOUT  = 16
);
    localparam int CW = piloop_mc_pkg::chan_w(NCH);
    localparam int WI = piloop_mc_pkg::integ_w(WIN, WK, WINTE);

    logic                   strobe_in;
    logic [CW-1:0]          chan_in;
    logic signed [WIN-1:0]  errin;
    logic                   clear;

    logic                   strobe_out;
    logic [CW-1:0]          chan_out;
    logic signed [WOUT-1:0] ctrl_out;
    logic signed [WI-PK-1:0] inte;
    logic [1:0]             sat;

    modport master (
        output strobe_in, chan_in, errin, clear,
        input  strobe_out, chan_out, ctrl_out, inte, sat
    );

    modport slave (
        input  strobe_in, chan_in, errin, clear,
        output strobe_out, chan_out, ctrl_out, inte, sat
    );

endinterface

`default_nettype wire

// File: rtl/piloop_sat.sv
// ============================================================================
// piloop_sat : signed saturation from WA to WB bits with {hi,lo} flags
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module piloop_sat #(
    parameter int WA = 41,
    parameter int WB = 23
) (
    input  logic signed [WA-1:0] din,
    output logic signed [WB-1:0] dout,
    output logic                 hi,
    output logic                 lo
);

    generate
        if (WA > WB) begin : g_sat
            // Value fits when every bit from the sign down to WB-1 agrees
            logic [WA-WB:0] top;
            assign top = din[WA-1:WB-1];

            always_comb begin
                hi   = 1'b0;
                lo   = 1'b0;
                dout = din[WB-1:0];
                if (!top[WA-WB] && (|top)) begin
                    hi   = 1'b1;
                    dout = {1'b0, {(WB-1){1'b1}}};
                end else if (top[WA-WB] && !(&top)) begin
                    lo   = 1'b1;
                    dout = {1'b1, {(WB-1){1'b0}}};
                end
            end
        end else begin : g_pass
            assign dout = WB'(din);
            assign hi   = 1'b0;
            assign lo   = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/piloop_mc.sv
// ============================================================================
// piloop_mc : time-multiplexed NCH-channel PI controller, one shared datapath
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module piloop_mc
    import piloop_mc_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int WIN   = 16,
    parameter int WK    = 16,
    parameter int PK    = 7,
    parameter int WINTE = 8,
    parameter int WOUT  = 16,
    parameter int CLAMP = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    piloop_mc_if.slave          bus,
    input  logic                clear_all,
    input  logic [NCH*WK-1:0]   kp,
    input  logic [NCH*WK-1:0]   ki,
    input  logic [NCH-1:0]      reverse,
    input  logic [NCH-1:0]      static_mode,
    input  logic [NCH*WOUT-1:0] ol_set
);

    localparam int CW   = chan_w(NCH);
    localparam int WI   = integ_w(WIN, WK, WINTE);
    localparam int WP   = WIN + WK + 1;
    localparam int WS   = WOUT + PK;
    localparam int WA1  = WI + 1;
    localparam int ILIM = (CLAMP != 0) ? WS : WI;

    logic [WK-1:0]   kp_a [NCH];
    logic [WK-1:0]   ki_a [NCH];
    logic [WOUT-1:0] ol_a [NCH];

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_unpack
            assign kp_a[c] = kp[c*WK +: WK];
            assign ki_a[c] = ki[c*WK +: WK];
            assign ol_a[c] = ol_set[c*WOUT +: WOUT];
        end
    endgenerate

    // ---------------- S1: capture sample, sign-apply gains ----------------
    logic                 w_valid;
    logic [CW-1:0]        w_idx;
    logic signed [WK:0]   w_kp_s;
    logic signed [WK:0]   w_ki_s;

    assign w_valid = bus.strobe_in && ({1'b0, bus.chan_in} < (CW+1)'(NCH));
    assign w_idx   = w_valid ? bus.chan_in : '0;
    assign w_kp_s  = $signed({1'b0, kp_a[w_idx]});
    assign w_ki_s  = $signed({1'b0, ki_a[w_idx]});

    logic                  s1_v, s1_clr;
    logic [CW-1:0]         s1_ch;
    logic signed [WIN-1:0] s1_err;
    logic signed [WK:0]    s1_gp, s1_gi;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_v   <= 1'b0;
            s1_clr <= 1'b0;
            s1_ch  <= '0;
            s1_err <= '0;
            s1_gp  <= '0;
            s1_gi  <= '0;
        end else begin
            s1_v   <= w_valid;
            s1_clr <= bus.clear;
            s1_ch  <= w_idx;
            s1_err <= bus.errin;
            s1_gp  <= reverse[w_idx] ? -w_kp_s : w_kp_s;
            s1_gi  <= reverse[w_idx] ? -w_ki_s : w_ki_s;
        end
    end

    // ---------------- S2: shared multiplier pair ----------------
    logic signed [WP-1:0] w_pp, w_pi;
    assign w_pp = WP'(s1_err) * WP'(s1_gp);
    assign w_pi = WP'(s1_err) * WP'(s1_gi);

    logic                 s2_v, s2_clr;
    logic [CW-1:0]        s2_ch;
    logic signed [WP-1:0] s2_pp, s2_pi;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_v   <= 1'b0;
            s2_clr <= 1'b0;
            s2_ch  <= '0;
            s2_pp  <= '0;
            s2_pi  <= '0;
        end else begin
            s2_v   <= s1_v;
            s2_clr <= s1_clr;
            s2_ch  <= s1_ch;
            s2_pp  <= w_pp;
            s2_pi  <= w_pi;
        end
    end

    // ---------------- S3: integrator read-modify-write ----------------
    logic signed [WI-1:0]   integ [NCH];
    logic signed [WA1-1:0]  w_acc;
    logic signed [ILIM-1:0] w_lim;
    logic signed [WI-1:0]   w_new;

    assign w_acc = WA1'(integ[s2_ch]) + WA1'(s2_pi);

    piloop_sat #(.WA(WA1), .WB(ILIM)) u_sat_integ (
        .din  (w_acc),
        .dout (w_lim),
        .hi   (),
        .lo   ()
    );

    assign w_new = s2_clr ? '0 : WI'(w_lim);

    // clear_all takes priority over the per-sample write landing this edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NCH; c++) integ[c] <= '0;
        end else if (clear_all) begin
            for (int c = 0; c < NCH; c++) integ[c] <= '0;
        end else if (s2_v) begin
            integ[s2_ch] <= w_new;
        end
    end

    logic                 s3_v;
    logic [CW-1:0]        s3_ch;
    logic signed [WP-1:0] s3_p;
    logic signed [WI-1:0] s3_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s3_v  <= 1'b0;
            s3_ch <= '0;
            s3_p  <= '0;
            s3_i  <= '0;
        end else begin
            s3_v  <= s2_v;
            s3_ch <= s2_ch;
            s3_p  <= s2_pp;
            s3_i  <= clear_all ? '0 : w_new;
        end
    end

    // ---------------- S4: P+I adder ----------------
    logic                  s4_v;
    logic [CW-1:0]         s4_ch;
    logic signed [WA1-1:0] s4_sum;
    logic signed [WI-1:0]  s4_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s4_v   <= 1'b0;
            s4_ch  <= '0;
            s4_sum <= '0;
            s4_i   <= '0;
        end else begin
            s4_v   <= s3_v;
            s4_ch  <= s3_ch;
            s4_sum <= WA1'(s3_p) + WA1'(s3_i);
            s4_i   <= s3_i;
        end
    end

    // ---------------- Output: saturate, open-loop override ----------------
    logic signed [WS-1:0] w_sum_sat;
    logic                 w_hi, w_lo;

    piloop_sat #(.WA(WA1), .WB(WS)) u_sat_out (
        .din  (s4_sum),
        .dout (w_sum_sat),
        .hi   (w_hi),
        .lo   (w_lo)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.strobe_out <= 1'b0;
            bus.chan_out   <= '0;
            bus.ctrl_out   <= '0;
            bus.inte       <= '0;
            bus.sat        <= SAT_NONE;
        end else begin
            bus.strobe_out <= s4_v;
            if (s4_v) begin
                bus.chan_out <= s4_ch;
                bus.inte     <= s4_i[WI-1:PK];
                if (static_mode[s4_ch]) begin
                    bus.ctrl_out <= ol_a[s4_ch];
                    bus.sat      <= SAT_NONE;
                end else begin
                    bus.ctrl_out <= w_sum_sat[WS-1:PK];
                    bus.sat      <= {w_hi, w_lo};
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_piloop_mc.sv
// ============================================================================
// tb_piloop_mc : directed stimulus, arithmetic reference model, per-cycle compare
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_piloop_mc;

    localparam int NCH = 4;
    localparam int WK  = 16;
    localparam int WOUT = 16;
    localparam int PK  = 7;
    localparam int WS  = WOUT + PK;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clear_all = 1'b0;
    logic [NCH*WK-1:0]   kp_v = '0, ki_v = '0;
    logic [NCH-1:0]      rev_v = '0, stat_v = '0;
    logic [NCH*WOUT-1:0] ol_v = '0;

    logic [5*WK-1:0]   kp5 = '0;
    logic [5*WK-1:0]   ki5 = {5{16'd128}};
    logic [4:0]        zero5 = '0;
    logic [5*WOUT-1:0] ol5 = '0;

    piloop_mc_if #(.NCH(NCH)) bus ();
    piloop_mc_if #(.NCH(5))   bus5 ();

    piloop_mc dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .clear_all(clear_all),
        .kp(kp_v), .ki(ki_v), .reverse(rev_v), .static_mode(stat_v), .ol_set(ol_v)
    );

    piloop_mc #(.NCH(5)) dut5 (
        .clk(clk), .reset_n(reset_n), .bus(bus5), .clear_all(1'b0),
        .kp(kp5), .ki(ki5), .reverse(zero5), .static_mode(zero5), .ol_set(ol5)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int vectors = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    typedef struct { int ch; bit clr; longint p; longint pi; int due; } pend_t;
    typedef struct { int ch; longint p; longint i; int due; } res_t;
    pend_t  pq[$];
    res_t   rq[$];
    longint m_integ [NCH];
    int     cyc_m = 0;
    pend_t  me;
    res_t   mr;
    longint msum, minew, merr;
    bit     exp_v = 1'b0;
    int     exp_ch = 0, exp_sat = 0;
    longint exp_ctrl = 0, exp_inte = 0;

    function automatic longint lim(input longint v, input int w);
        longint hi, lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    function automatic longint gain(input logic [NCH*WK-1:0] k, input logic [NCH-1:0] r, input int ch);
        longint g;
        g = longint'(k[ch*WK +: WK]);
        return r[ch] ? -g : g;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pq.delete();
            rq.delete();
            foreach (m_integ[c]) m_integ[c] = 0;
            exp_v = 1'b0;
        end else begin
            exp_v = 1'b0;
            if (rq.size() > 0 && rq[0].due == cyc_m) begin
                mr = rq.pop_front();
                msum = mr.p + mr.i;
                exp_v = 1'b1;
                exp_ch = mr.ch;
                exp_inte = mr.i >>> PK;
                if (stat_v[mr.ch]) begin
                    exp_ctrl = longint'($signed(ol_v[mr.ch*WOUT +: WOUT]));
                    exp_sat = 0;
                end else begin
                    exp_ctrl = lim(msum, WS) >>> PK;
                    exp_sat = (msum > lim(msum, WS)) ? 2 : ((msum < lim(msum, WS)) ? 1 : 0);
                end
            end
            if (pq.size() > 0 && pq[0].due == cyc_m) begin
                me = pq.pop_front();
                if (clear_all) minew = 0;
                else begin
                    minew = me.clr ? 0 : lim(m_integ[me.ch] + me.pi, WS);
                    m_integ[me.ch] = minew;
                end
                rq.push_back('{me.ch, me.p, minew, cyc_m + 2});
            end
            if (clear_all) foreach (m_integ[c]) m_integ[c] = 0;
            if (bus.strobe_in && int'(bus.chan_in) < NCH) begin
                merr = longint'($signed(bus.errin));
                pq.push_back('{int'(bus.chan_in), bus.clear,
                               merr * gain(kp_v, rev_v, int'(bus.chan_in)),
                               merr * gain(ki_v, rev_v, int'(bus.chan_in)), cyc_m + 2});
            end
            cyc_m++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        vectors++;
        if (bus.strobe_out !== exp_v) begin
            miscompares++;
            $display("FAIL strobe_out cyc=%0d: got %b expected %b", cyc, bus.strobe_out, exp_v);
        end else if (exp_v) begin
            vectors++;
            if (int'(bus.chan_out) != exp_ch || longint'($signed(bus.ctrl_out)) != exp_ctrl ||
                longint'($signed(bus.inte)) != exp_inte || int'(bus.sat) != exp_sat) begin
                miscompares++;
                $display("FAIL result cyc=%0d: got ch=%0d ctrl=%0d inte=%0d sat=%0d expected ch=%0d ctrl=%0d inte=%0d sat=%0d",
                         cyc, bus.chan_out, $signed(bus.ctrl_out), $signed(bus.inte), bus.sat,
                         exp_ch, exp_ctrl, exp_inte, exp_sat);
            end
        end
    end

    // ---------------- output log for literal checks ----------------
    typedef struct { int ch; longint ctrl; longint inte; int sat; int cyc; } obs_t;
    obs_t obs[$];
    int count5 = 0;
    int last5_ch = -1;
    longint last5_ctrl = -1;

    always @(negedge clk) begin
        if (bus.strobe_out)
            obs.push_back('{int'(bus.chan_out), longint'($signed(bus.ctrl_out)),
                            longint'($signed(bus.inte)), int'(bus.sat), cyc});
        if (bus5.strobe_out) begin
            count5++;
            last5_ch = int'(bus5.chan_out);
            last5_ctrl = longint'($signed(bus5.ctrl_out));
        end
    end

    function automatic obs_t ob(input int i);
        obs_t o;
        o = '{-1, -999999, -999999, -1, -1};
        if (i >= 0 && i < obs.size()) o = obs[i];
        return o;
    endfunction

    task automatic chk(input string nm, input longint act, input longint expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic send(input int ch, input int err, input bit clr);
        bus.strobe_in = 1'b1;
        bus.chan_in   = ch[1:0];
        bus.errin     = err[15:0];
        bus.clear     = clr;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.strobe_in = 1'b0;
        bus.clear     = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send5(input int ch, input int err);
        bus5.strobe_in = 1'b1;
        bus5.chan_in   = ch[2:0];
        bus5.errin     = err[15:0];
        @(negedge clk);
        bus5.strobe_in = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    int t0;

    initial begin
        bus.strobe_in = 1'b0; bus.chan_in = '0; bus.errin = '0; bus.clear = 1'b0;
        bus5.strobe_in = 1'b0; bus5.chan_in = '0; bus5.errin = '0; bus5.clear = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset strobe_out", longint'(bus.strobe_out), 0);
        chk("reset chan_out", longint'(bus.chan_out), 0);
        chk("reset ctrl_out", longint'($signed(bus.ctrl_out)), 0);
        chk("reset inte", longint'($signed(bus.inte)), 0);
        chk("reset sat", longint'(bus.sat), 0);
        reset_n = 1'b1;
        idle(2);

        // Pure integral on ch0, spaced strobes
        ki_v[0*WK +: WK] = 16'd128;
        obs.delete();
        t0 = cyc + 1;
        send(0, 100, 0); idle(2);
        send(0, 100, 0); idle(2);
        send(0, 100, 0); idle(8);
        chk("t1 count", obs.size(), 3);
        chk("t1 ctrl0", ob(0).ctrl, 100);
        chk("t1 ctrl1", ob(1).ctrl, 200);
        chk("t1 ctrl2", ob(2).ctrl, 300);
        chk("t1 latency", ob(0).cyc - t0, 4);

        // Pure proportional on ch1, then reversed
        kp_v[1*WK +: WK] = 16'd256;
        obs.delete();
        send(1, -50, 0); send(1, -50, 0); idle(8);
        chk("t2 ctrl", ob(obs.size()-1).ctrl, -100);
        rev_v[1] = 1'b1;
        obs.delete();
        send(1, -50, 0); idle(8);
        chk("t2 reverse ctrl", ob(0).ctrl, 100);

        // Saturation and anti-windup on ch2
        kp_v[2*WK +: WK] = 16'd128;
        ki_v[2*WK +: WK] = 16'd65535;
        obs.delete();
        repeat (4) send(2, 32767, 0);
        idle(8);
        chk("t3 sat ctrl", ob(3).ctrl, 32767);
        chk("t3 sat flags", ob(3).sat, 2);
        kp_v[2*WK +: WK] = 16'd0;
        ki_v[2*WK +: WK] = 16'd128;
        obs.delete();
        send(2, -1, 0); idle(8);
        chk("t3 unwind ctrl", ob(0).ctrl, 32766);
        chk("t3 unwind sat", ob(0).sat, 0);

        // Interleaved channels, ch0 back to back
        rev_v = '0;
        kp_v[0*WK +: WK] = 16'd64;  ki_v[0*WK +: WK] = 16'd32;
        kp_v[1*WK +: WK] = 16'd0;   ki_v[1*WK +: WK] = 16'd200;
        kp_v[3*WK +: WK] = 16'd300; ki_v[3*WK +: WK] = 16'd5;
        obs.delete();
        send(0, 10, 0); send(0, -7, 0); send(1, 20, 0);
        send(2, 5, 0); send(3, -1000, 0); send(0, 3, 0);
        idle(8);
        chk("t4 count", obs.size(), 6);
        send(0, 50, 1); idle(8);
        chk("t4 clear inte", ob(obs.size()-1).inte, 0);
        chk("t4 clear ctrl", ob(obs.size()-1).ctrl, 25);

        // Open-loop ch3 with integrator running, then clear_all
        stat_v[3] = 1'b1;
        ol_v[3*WOUT +: WOUT] = 16'h1234;
        obs.delete();
        repeat (3) send(3, 100, 0);
        idle(8);
        chk("t5 static ctrl", ob(0).ctrl, 4660);
        chk("t5 static sat", ob(2).sat, 0);
        chk("t5 inte runs", ob(2).inte, -28);
        send(3, 100, 0);
        clear_all = 1'b1;
        send(3, 100, 0);
        clear_all = 1'b0;
        send(3, 100, 0); send(3, 100, 0);
        idle(8);
        clear_all = 1'b1;
        @(negedge clk);
        clear_all = 1'b0;
        obs.delete();
        send(3, 0, 0); idle(8);
        chk("t5 cleared inte", ob(0).inte, 0);
        chk("t5 cleared ctrl", ob(0).ctrl, 4660);

        // Invalid channel on the five-channel instance
        send5(5, 100);
        chk("t6 invalid chan strobes", count5, 0);
        send5(0, 100);
        chk("t6 valid chan strobes", count5, 1);
        chk("t6 valid ctrl", last5_ctrl, 100);
        send5(4, 100);
        chk("t6 top chan", last5_ch, 4);

        // Reset in the middle of a burst
        kp_v[0*WK +: WK] = 16'd0; ki_v[0*WK +: WK] = 16'd128;
        stat_v = '0;
        obs.delete();
        send(1, 40, 0); send(2, 40, 0);
        bus.strobe_in = 1'b1; bus.chan_in = 2'd0; bus.errin = 16'd40;
        #2 reset_n = 1'b0;
        #1;
        chk("t6 reset strobe_out", longint'(bus.strobe_out), 0);
        chk("t6 reset ctrl_out", longint'($signed(bus.ctrl_out)), 0);
        @(negedge clk);
        idle(2);
        reset_n = 1'b1;
        idle(8);
        chk("t6 no stray strobe", obs.size(), 0);
        send(0, 100, 0); idle(8);
        chk("t6 integ zeroed", ob(0).ctrl, 100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
